// File: rtl/ysyx_23060229_ifu_pkg.sv
// Shared IFU definitions: FSM state encodings, fault cause codes, fault record.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Also imported by the IDU/EXU and the bench.
package ysyx_23060229_ifu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } ifu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_BUS      = 2'd1,
        CAUSE_MISALIGN = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } fault_cause_t;

    // Captured once on entry to FAULT and held until reset.
    typedef struct packed {
        fault_cause_t cause;
        logic [31:0]  pc;
    } fault_rec_t;

    localparam int WDT_W = 8;

    // Instructions are word aligned; the EXU must never hand back anything else.
    function automatic logic npc_aligned(input logic [31:0] npc);
        return npc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060229_ifu_wdt.sv
// Watchdog: 8-bit saturating cycle counter with clear, enable and expire.
// Latency: expire is combinational, high in the LIMIT-th consecutive enabled cycle.
// Backpressure: none; clr has priority over counting.
// Ports: clk, rst (sync, active high), clr, en in; expire out.
module ysyx_23060229_ifu_wdt
    import ysyx_23060229_ifu_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // count holds the number of enabled cycles already elapsed, so the cycle
    // that would make it reach LIMIT is the one flagged as expired.
    localparam logic [WDT_W-1:0] LIM_M1 = WDT_W'(LIMIT - 1);

    logic [WDT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count >= LIM_M1);

endmodule

// File: rtl/ysyx_23060229_ifu.sv
// Instruction fetch: holds the PC, fetches one word per retirement, hands {inst,pc} to the IDU.
// Latency: reset/redirect to req_valid 1 cycle; req handshake to out_valid = rsp latency + 1.
// Backpressure: req_addr held until req_ready, {inst,pc} held until out_ready; watchdog faults stalls.
// Ports: clk, rst | req_valid/req_ready/req_addr | rsp_valid/rsp_data/rsp_err |
//        out_valid/out_ready/inst/pc | wb_valid/wb_npc | fault/fault_cause/fault_pc
module ysyx_23060229_ifu
    import ysyx_23060229_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        wb_valid,
    input  logic [31:0] wb_npc,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc
);

    ifu_state_t state, state_nxt;
    fault_rec_t fault_q, fault_nxt;
    logic       fault_set;
    logic [31:0] pc_q, inst_q;
    logic       req_hs;
    logic       wdt_en, wdt_clr, wdt_expire;

    assign req_hs = req_valid && req_ready;

    // Watchdog restarts on every state change and only runs while waiting
    // on the memory side.
    assign wdt_clr = (state_nxt != state);

    ysyx_23060229_ifu_wdt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clr    (wdt_clr),
        .en     (wdt_en),
        .expire (wdt_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and fault capture. Handshakes are tested before the watchdog
    // so a response or acceptance in the final allowed cycle still succeeds.
    always_comb begin
        state_nxt = state;
        fault_set = 1'b0;
        fault_nxt = '0;
        unique case (state)
            ST_FETCH: begin
                if (req_hs) begin
                    state_nxt = ST_WAIT;
                end else if (wdt_expire) begin
                    state_nxt       = ST_FAULT;
                    fault_set       = 1'b1;
                    fault_nxt.cause = CAUSE_TIMEOUT;
                    fault_nxt.pc    = pc_q;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_err) begin
                        state_nxt       = ST_FAULT;
                        fault_set       = 1'b1;
                        fault_nxt.cause = CAUSE_BUS;
                        fault_nxt.pc    = pc_q;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end else if (wdt_expire) begin
                    state_nxt       = ST_FAULT;
                    fault_set       = 1'b1;
                    fault_nxt.cause = CAUSE_TIMEOUT;
                    fault_nxt.pc    = pc_q;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (wb_valid) begin
                    if (npc_aligned(wb_npc)) begin
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt       = ST_FAULT;
                        fault_set       = 1'b1;
                        fault_nxt.cause = CAUSE_MISALIGN;
                        fault_nxt.pc    = wb_npc;
                    end
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    // Moore outputs decoded from the state alone.
    always_comb begin
        req_valid = (state == ST_FETCH);
        out_valid = (state == ST_HOLD);
        fault     = (state == ST_FAULT);
        wdt_en    = (state == ST_FETCH) || (state == ST_WAIT);
    end

    // PC, instruction and fault record. The PC only moves on a clean
    // retirement; a misaligned npc is recorded but never loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            fault_q <= '0;
        end else begin
            if ((state == ST_WAIT) && rsp_valid && !rsp_err) begin
                inst_q <= rsp_data;
            end
            if ((state == ST_EXEC) && wb_valid && npc_aligned(wb_npc)) begin
                pc_q <= wb_npc;
            end
            if (fault_set) begin
                fault_q <= fault_nxt;
            end
        end
    end

    assign req_addr    = pc_q;
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign fault_cause = fault_q.cause;
    assign fault_pc    = fault_q.pc;

endmodule

// File: tb/tb_ysyx_23060229_ifu.sv
// Bench for ysyx_23060229_ifu: directed stimulus feeding expectation queues,
// a negedge monitor compares every handshake and requested snapshot.
// Stimulus drives at posedge+1; monitor samples at negedge.
module tb_ysyx_23060229_ifu;
    import ysyx_23060229_ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TO     = 8;

    typedef struct packed {
        logic        req_valid;
        logic [31:0] req_addr;
        logic        out_valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
        logic [1:0]  fault_cause;
        logic [31:0] fault_pc;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        out_valid, out_ready;
    logic [31:0] inst, pc;
    logic        wb_valid;
    logic [31:0] wb_npc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;

    always #5 clk = ~clk;

    ysyx_23060229_ifu #(
        .RESET_PC    (RST_PC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .inst        (inst),
        .pc          (pc),
        .wb_valid    (wb_valid),
        .wb_npc      (wb_npc),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_pc    (fault_pc)
    );

    // Expectation queues filled by stimulus, drained by the monitor.
    logic [31:0] exp_req_q[$];
    logic [63:0] exp_out_q[$];
    snap_t       exp_snap_q[$];
    string       snap_name_q[$];

    int n_checks = 0;
    int n_errs   = 0;
    bit done     = 1'b0;

    logic [31:0] cur_pc, cur_inst;

    task automatic chk(input string name, input bit ok,
                       input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (!ok) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    snap_t       act_s, e_s;
    string       nm;
    logic [31:0] e32, prev_addr;
    logic [63:0] e64, prev_out;
    bit          hold_req = 1'b0;
    bit          hold_out = 1'b0;

    always @(negedge clk) begin
        act_s = {req_valid, req_addr, out_valid, inst, pc, fault, fault_cause, fault_pc};
        if (!rst) begin
            if (hold_req)
                chk("req_stable", fault || (req_valid && (req_addr == prev_addr)),
                    {104'b0, req_addr}, {104'b0, prev_addr});
            if (hold_out)
                chk("out_stable", out_valid && ({inst, pc} == prev_out),
                    {72'b0, inst, pc}, {72'b0, prev_out});
            if (req_valid && req_ready) begin
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", 1'b0, {104'b0, req_addr}, 136'b0);
                end else begin
                    e32 = exp_req_q.pop_front();
                    chk("req_addr", req_addr == e32, {104'b0, req_addr}, {104'b0, e32});
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) begin
                    chk("idu_unexpected", 1'b0, {72'b0, inst, pc}, 136'b0);
                end else begin
                    e64 = exp_out_q.pop_front();
                    chk("idu_inst_pc", {inst, pc} == e64, {72'b0, inst, pc}, {72'b0, e64});
                end
            end
        end
        hold_req  = !rst && req_valid && !req_ready;
        prev_addr = req_addr;
        hold_out  = !rst && out_valid && !out_ready;
        prev_out  = {inst, pc};
        while (exp_snap_q.size() > 0) begin
            e_s = exp_snap_q.pop_front();
            nm  = snap_name_q.pop_front();
            chk(nm, act_s == e_s, {3'b0, act_s}, {3'b0, e_s});
        end
        if (done) begin
            chk("queues_drained", (exp_req_q.size() == 0) && (exp_out_q.size() == 0),
                {72'b0, 32'(exp_req_q.size()), 32'(exp_out_q.size())}, 136'b0);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
            $finish;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap(input string name, input logic rv, input logic ov,
                        input logic f, input logic [1:0] c, input logic [31:0] fpc);
        snap_t s;
        s = {rv, cur_pc, ov, cur_inst, cur_pc, f, c, fpc};
        exp_snap_q.push_back(s);
        snap_name_q.push_back(name);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        rsp_data = '0; out_ready = 1'b0; wb_valid = 1'b0; wb_npc = '0;
        step(2);
        rst = 1'b0;
        cur_pc = RST_PC;
        cur_inst = '0;
        snap(name, 1'b1, 1'b0, 1'b0, CAUSE_NONE, 32'h0);
    endtask

    task automatic fetch_hs(input int req_delay);
        req_ready = 1'b0;
        step(req_delay);
        req_ready = 1'b1;
        exp_req_q.push_back(cur_pc);
        step(1);
        req_ready = 1'b0;
    endtask

    task automatic respond(input int rsp_delay, input logic [31:0] data, input logic err);
        step(rsp_delay);
        rsp_valid = 1'b1; rsp_data = data; rsp_err = err;
        if (!err) begin
            cur_inst = data;
            exp_out_q.push_back({data, cur_pc});
        end
        step(1);
        rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    endtask

    task automatic accept(input int delay);
        out_ready = 1'b0;
        step(delay);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    task automatic retire(input logic [31:0] npc);
        wb_valid = 1'b1; wb_npc = npc;
        step(1);
        wb_valid = 1'b0; wb_npc = '0;
        if (npc[1:0] == 2'b00) cur_pc = npc;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        rsp_data = '0; out_ready = 1'b0; wb_valid = 1'b0; wb_npc = '0;
        cur_pc = RST_PC; cur_inst = '0;

        // 1: basic fetch from reset
        do_reset("t1_reset");
        fetch_hs(0);
        snap("t1_wait", 1'b0, 1'b0, 1'b0, CAUSE_NONE, 32'h0);
        respond(0, 32'h0000_0413, 1'b0);
        snap("t1_hold", 1'b0, 1'b1, 1'b0, CAUSE_NONE, 32'h0);
        accept(0);
        snap("t1_exec", 1'b0, 1'b0, 1'b0, CAUSE_NONE, 32'h0);

        // 3: redirect to 0x80000004
        retire(32'h8000_0004);
        snap("t3_redirect", 1'b1, 1'b0, 1'b0, CAUSE_NONE, 32'h0);

        // 2: req backpressure 3 cycles (stray rsp in FETCH ignored), IDU 4 cycles
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hdead_beef;
        step(1);
        rsp_valid = 1'b0; rsp_data = '0;
        step(2);
        snap("t2_fetch_stall", 1'b1, 1'b0, 1'b0, CAUSE_NONE, 32'h0);
        fetch_hs(0);
        respond(1, 32'h0010_0093, 1'b0);
        snap("t2_hold", 1'b0, 1'b1, 1'b0, CAUSE_NONE, 32'h0);
        wb_valid = 1'b1; wb_npc = 32'h8000_0010;
        step(1);
        wb_valid = 1'b0; wb_npc = '0;
        step(3);
        snap("t3_wb_in_hold", 1'b0, 1'b1, 1'b0, CAUSE_NONE, 32'h0);
        accept(0);
        snap("t2_exec", 1'b0, 1'b0, 1'b0, CAUSE_NONE, 32'h0);
        retire(32'h8000_0008);
        snap("t2_redirect", 1'b1, 1'b0, 1'b0, CAUSE_NONE, 32'h0);

        // 4: misaligned npc
        fetch_hs(0);
        respond(0, 32'h0000_0013, 1'b0);
        accept(1);
        retire(32'h8000_0006);
        snap("t4_misalign", 1'b0, 1'b0, 1'b1, CAUSE_MISALIGN, 32'h8000_0006);
        step(3);
        snap("t4_frozen", 1'b0, 1'b0, 1'b1, CAUSE_MISALIGN, 32'h8000_0006);

        // 6: reset while in FAULT, then bus error
        do_reset("t6_reset_in_fault");
        fetch_hs(1);
        respond(2, 32'hffff_ffff, 1'b1);
        snap("t4_bus_err", 1'b0, 1'b0, 1'b1, CAUSE_BUS, RST_PC);

        // 5: FETCH timeout
        do_reset("t5_reset");
        req_ready = 1'b0;
        step(TO - 1);
        snap("t5_fetch_pre", 1'b1, 1'b0, 1'b0, CAUSE_NONE, 32'h0);
        step(1);
        snap("t5_fetch_timeout", 1'b0, 1'b0, 1'b1, CAUSE_TIMEOUT, RST_PC);

        // 5: handshake in the final cycle wins, in FETCH and in WAIT
        do_reset("t5_reset2");
        fetch_hs(TO - 1);
        snap("t5_fetch_tie", 1'b0, 1'b0, 1'b0, CAUSE_NONE, 32'h0);
        respond(TO - 1, 32'h0000_0093, 1'b0);
        snap("t5_wait_tie", 1'b0, 1'b1, 1'b0, CAUSE_NONE, 32'h0);
        accept(0);
        retire(32'h8000_0100);

        // 5: WAIT timeout
        fetch_hs(0);
        step(TO - 1);
        snap("t5_wait_pre", 1'b0, 1'b0, 1'b0, CAUSE_NONE, 32'h0);
        step(1);
        snap("t5_wait_timeout", 1'b0, 1'b0, 1'b1, CAUSE_TIMEOUT, 32'h8000_0100);

        // 6: reset during WAIT, then clean refetch
        do_reset("t6_reset3");
        fetch_hs(0);
        step(2);
        do_reset("t6_reset_in_wait");
        fetch_hs(0);
        respond(0, 32'h0000_0513, 1'b0);
        snap("t6_hold", 1'b0, 1'b1, 1'b0, CAUSE_NONE, 32'h0);
        accept(0);
        snap("t6_exec", 1'b0, 1'b0, 1'b0, CAUSE_NONE, 32'h0);

        done = 1'b1;
        step(3);
        $display("FAIL monitor_no_finish: got running expected finished");
        $fatal(1);
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
